// File: rtl/byte_serializer.sv
// byte_serializer: pops bytes from a show-ahead queue and re-emits them as serial
// data/write strobe pairs with optional idle gaps, counting completed bytes.
module byte_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_GAP    = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  serializer_rst_n,
    input  logic                  enable_in,
    input  logic                  queue_empty_in,
    input  logic [DATA_WIDTH-1:0] queue_data_in,
    output logic                  dequeue_out,
    output logic                  data_out,
    output logic                  write_out,
    output logic                  busy_out,
    output logic [15:0]           sent_count_out
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [3:0] GAP_LAST = 4'((BIT_GAP > 0) ? BIT_GAP - 1 : 0);
    typedef enum logic [1:0] {IDLE, POP, SHIFT, GAP} state_t;
    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [3:0]            gap_cnt_q;
    logic                  dequeue_q, data_q, write_q, busy_q;
    logic [15:0]           sent_count_q;
    logic                  next_bit, last_bit;
    logic [DATA_WIDTH-1:0] shift_d;
    always_comb begin
        next_bit = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
        shift_d  = MSB_FIRST ? shift_q << 1 : shift_q >> 1;
        last_bit = bit_cnt_q == LAST_BIT;
    end
    // Outputs for a state are set on the edge entering it, so all are registered.
    always_ff @(posedge clk or negedge serializer_rst_n) begin
        if (!serializer_rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            dequeue_q    <= 1'b0;
            data_q       <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            sent_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (enable_in && !queue_empty_in) begin
                    state_q   <= POP;
                    shift_q   <= queue_data_in;
                    dequeue_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                POP: begin
                    state_q   <= SHIFT;
                    dequeue_q <= 1'b0;
                    write_q   <= 1'b1;
                    data_q    <= next_bit;
                    shift_q   <= shift_d;
                    bit_cnt_q <= '0;
                end
                SHIFT: if (BIT_GAP != 0) begin
                    state_q   <= GAP;
                    write_q   <= 1'b0;
                    gap_cnt_q <= GAP_LAST;
                end else if (last_bit) begin
                    state_q      <= IDLE;
                    write_q      <= 1'b0;
                    busy_q       <= 1'b0;
                    sent_count_q <= sent_count_q + 16'd1;
                end else begin
                    data_q    <= next_bit;
                    shift_q   <= shift_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                GAP: if (gap_cnt_q != 4'd0) begin
                    gap_cnt_q <= gap_cnt_q - 4'd1;
                end else if (last_bit) begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    sent_count_q <= sent_count_q + 16'd1;
                end else begin
                    state_q   <= SHIFT;
                    write_q   <= 1'b1;
                    data_q    <= next_bit;
                    shift_q   <= shift_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            endcase
        end
    end
    assign dequeue_out    = dequeue_q;
    assign data_out       = data_q;
    assign write_out      = write_q;
    assign busy_out       = busy_q;
    assign sent_count_out = sent_count_q;
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: two instances (default MSB-first/gap 1, and LSB-first/gap 0)
// checked every cycle against a per-byte schedule model, plus directed literals.
module tb_byte_serializer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        en[2], empty[2];
    logic [7:0]  qd[2];
    logic        deq[2], dat[2], wr[2], busy[2];
    logic [15:0] cnt[2];
    int vec = 0, miss = 0;

    always #5 clk = ~clk;

    byte_serializer u0 (
        .clk(clk), .serializer_rst_n(rst_n), .enable_in(en[0]), .queue_empty_in(empty[0]),
        .queue_data_in(qd[0]), .dequeue_out(deq[0]), .data_out(dat[0]), .write_out(wr[0]),
        .busy_out(busy[0]), .sent_count_out(cnt[0]));
    byte_serializer #(.DATA_WIDTH(8), .BIT_GAP(0), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .serializer_rst_n(rst_n), .enable_in(en[1]), .queue_empty_in(empty[1]),
        .queue_data_in(qd[1]), .dequeue_out(deq[1]), .data_out(dat[1]), .write_out(wr[1]),
        .busy_out(busy[1]), .sent_count_out(cnt[1]));

    function automatic int gap(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: k = cycles since the pop edge (-1 when idle); outputs follow from k.
    int          k[2];
    logic [7:0]  mb[2];
    logic        e_deq[2], e_wr[2], e_dat[2], e_busy[2];
    logic [15:0] e_cnt[2];
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                k[d] = -1; e_deq[d] = 0; e_wr[d] = 0; e_dat[d] = 0; e_busy[d] = 0; e_cnt[d] = 0;
            end else begin
                if (k[d] < 0) begin
                    if (en[d] && !empty[d]) begin k[d] = 0; mb[d] = qd[d]; end
                end else if (k[d] == 8 * (1 + gap(d))) begin
                    k[d] = -1;
                    e_cnt[d] = e_cnt[d] + 16'd1;
                end else k[d]++;
                e_deq[d]  = (k[d] == 0);
                e_busy[d] = (k[d] >= 0);
                e_wr[d]   = 0;
                if (k[d] > 0 && (k[d] - 1) % (1 + gap(d)) == 0) begin
                    automatic int i = (k[d] - 1) / (1 + gap(d));
                    e_wr[d]  = 1;
                    e_dat[d] = (d == 0) ? mb[d][7 - i] : mb[d][i];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dequeue%0d", d), deq[d], e_deq[d]);
            chk($sformatf("write%0d", d), wr[d], e_wr[d]);
            chk($sformatf("data%0d", d), dat[d], e_dat[d]);
            chk($sformatf("busy%0d", d), busy[d], e_busy[d]);
            chk($sformatf("count%0d", d), cnt[d], e_cnt[d]);
        end
    end

    // Behavioural deserializer and pop recorder.
    int         cyc = 0, nb[2], pops[2], run[2], last_run[2], pop_t[$];
    logic       first_bit[2];
    logic [7:0] sr[2], rxq0[$], rxq1[$];
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                nb[d] = 0; pops[d] = 0; run[d] = 0; last_run[d] = 0; sr[d] = 0; first_bit[d] = 0;
                if (d == 0) begin rxq0.delete(); pop_t.delete(); end else rxq1.delete();
            end else begin
                if (deq[d]) begin
                    pops[d]++;
                    if (d == 0) pop_t.push_back(cyc);
                end
                if (wr[d]) begin
                    if (nb[d] == 0) first_bit[d] = dat[d];
                    sr[d] = (d == 0) ? {sr[d][6:0], dat[d]} : {dat[d], sr[d][7:1]};
                    nb[d]++;
                    run[d]++;
                    if (nb[d] == 8) begin
                        if (d == 0) rxq0.push_back(sr[d]); else rxq1.push_back(sr[d]);
                        nb[d] = 0;
                    end
                end else if (run[d] > 0) begin
                    last_run[d] = run[d];
                    run[d] = 0;
                end
            end
        end
    end

    function automatic logic [31:0] rx(input int d, input int i);
        if (d == 0) return (i >= 0 && i < rxq0.size()) ? 32'(rxq0[i]) : 32'h1FF;
        return (i >= 0 && i < rxq1.size()) ? 32'(rxq1[i]) : 32'h1FF;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 0; tick(2); rst_n = 1; tick(1);
    endtask

    task automatic feed(input int d, input logic [7:0] b, input bit last);
        int t = 0;
        qd[d] = b; empty[d] = 0;
        tick(1);
        while (!deq[d] && t < 40) begin tick(1); t++; end
        chk("feed_dequeue_seen", deq[d], 1);
        if (last) empty[d] = 1;
    endtask

    task automatic wait_idle(input int d);
        int t = 0;
        while ((busy[d] || deq[d]) && t < 100) begin tick(1); t++; end
        chk("wait_idle_timeout", busy[d], 0);
    endtask

    task automatic wait_bits(input int d, input int n);
        int t = 0;
        while (!(wr[d] && nb[d] == n) && t < 100) begin tick(1); t++; end
        chk("wait_bits_timeout", nb[d], n);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin en[d] = 0; empty[d] = 1; qd[d] = 0; end
        rst_n = 0;
        tick(3);
        chk("rst_busy", busy[0], 0);
        chk("rst_count", cnt[0], 0);
        chk("rst_write", wr[0], 0);
        rst_n = 1;
        // Empty queue, enabled: nothing must happen
        en[0] = 1; en[1] = 1;
        tick(50);
        chk("t1_pops", pops[0] + pops[1], 0);
        chk("t1_count", cnt[0], 0);
        en[1] = 0;
        // Single byte A5
        feed(0, 8'hA5, 1);
        wait_idle(0);
        chk("t2_rx", rx(0, 0), 8'hA5);
        chk("t2_pops", pops[0], 1);
        chk("t2_count", cnt[0], 1);
        do_reset();
        // Three bytes back to back
        feed(0, 8'h3C, 0);
        feed(0, 8'hFF, 0);
        feed(0, 8'h00, 1);
        wait_idle(0);
        chk("t3_gap01", pop_t.size() > 1 ? pop_t[1] - pop_t[0] : 0, 18);
        chk("t3_gap12", pop_t.size() > 2 ? pop_t[2] - pop_t[1] : 0, 18);
        chk("t3_pops", pops[0], 3);
        chk("t3_count", cnt[0], 3);
        chk("t3_rx0", rx(0, 0), 8'h3C);
        chk("t3_rx1", rx(0, 1), 8'hFF);
        chk("t3_rx2", rx(0, 2), 8'h00);
        do_reset();
        // LSB first, no gap
        en[0] = 0; en[1] = 1;
        feed(1, 8'h01, 1);
        wait_idle(1);
        chk("t4_run", last_run[1], 8);
        chk("t4_first", first_bit[1], 1);
        chk("t4_rx", rx(1, 0), 8'h01);
        chk("t4_count", cnt[1], 1);
        en[1] = 0;
        do_reset();
        // Enable dropped mid-byte
        en[0] = 1;
        feed(0, 8'h81, 0);
        qd[0] = 8'h77;
        wait_bits(0, 3);
        en[0] = 0;
        tick(60);
        chk("t5_pops", pops[0], 1);
        chk("t5_rx", rx(0, 0), 8'h81);
        chk("t5_count", cnt[0], 1);
        empty[0] = 1;
        do_reset();
        // Reset in the middle of a byte
        en[0] = 1;
        feed(0, 8'hC3, 1);
        wait_bits(0, 4);
        rst_n = 0;
        #1;
        chk("t6_write", wr[0], 0);
        chk("t6_busy", busy[0], 0);
        chk("t6_data", dat[0], 0);
        chk("t6_count", cnt[0], 0);
        tick(2); rst_n = 1; tick(1);
        feed(0, 8'h96, 1);
        wait_idle(0);
        chk("t6_rx", rx(0, 0), 8'h96);
        chk("t6_count_after", cnt[0], 1);
        // Counter wrap
        force u0.sent_count_q = 16'hFFFF;
        e_cnt[0] = 16'hFFFF;
        tick(1);
        release u0.sent_count_q;
        feed(0, 8'h12, 1);
        wait_idle(0);
        chk("t7_wrap", cnt[0], 16'h0000);
        // Loopback
        feed(0, 8'h5A, 1);
        wait_idle(0);
        chk("t8_loop", rx(0, rxq0.size() - 1), 8'h5A);
        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++) begin
                en[d]    = $urandom_range(0, 7) != 0;
                empty[d] = $urandom_range(0, 2) == 0;
                qd[d]    = 8'($urandom);
            end
            if ($urandom_range(0, 999) == 0) begin rst_n = 0; tick(1); rst_n = 1; end
            tick(1);
        end
        en[0] = 0; en[1] = 0;
        tick(40);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
